// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: default modulus/width, Barrett constants, coefficient types.
// Used by the multiplier, the Barrett reducer and the butterfly stages.
// Pure declarations; no logic.
package ntt_pkg;

  localparam int NTT_W = 14;
  localparam int NTT_Q = 12289;

  // floor(2**(2k) / q), evaluated at elaboration time
  function automatic int unsigned barrett_mu(input int unsigned q, input int unsigned k);
    logic [63:0] num;
    num = 64'd1 << (2 * k);
    return 32'(num / 64'(q));
  endfunction

  localparam int K  = NTT_W;
  localparam int MU = int'(barrett_mu(NTT_Q, K));

  typedef logic [NTT_W-1:0]   coef_t;
  typedef logic [2*NTT_W-1:0] prod_t;

endpackage

// File: rtl/mod_pipe_stage.sv
// En-gated pipeline register carrying a valid bit and a payload; async active-low clear.
// Latency 1 en-qualified edge.
// Holds valid and payload whenever en is low.
module mod_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          valid_d,
  input  logic [DW-1:0] data_d,
  output logic          valid_q,
  output logic [DW-1:0] data_q
);

  // Shift valid and payload together on every enabled edge; bubbles shift too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mod_barrett_reduce.sv
// Barrett reduction of a 2W-bit product to x mod Q, with a sideband tag carried alongside.
// Latency 4 en-qualified edges (accepting edge counts as the first); throughput 1/cycle.
// Whole-pipe stall while valid_o & ~ready_i; ready_o = ~valid_o | ready_i. Optional MOD_BARRETT_RANGE_CHECK_EN adds sticky range_err_o.
module mod_barrett_reduce
  import ntt_pkg::*;
#(
  parameter int W     = NTT_W,
  parameter int Q     = NTT_Q,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2*W-1:0]   x_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [W-1:0]     r_o,
  output logic [TAG_W-1:0] tag_o
`ifdef MOD_BARRETT_RANGE_CHECK_EN
  ,
  output logic             range_err_o
`endif
);

  // Widths: x is 2W, t = (x>>(W-1))*MU is 2W+2, qh is W+1.
  // The final difference is below 3Q < 2**(W+2), so x and p are only needed mod 2**(W+2).
  localparam int XW  = 2 * W;
  localparam int TW  = 2 * W + 2;
  localparam int QHW = W + 1;
  localparam int PW  = 2 * W + 1;
  localparam int DW  = W + 2;
  localparam int unsigned BMU = barrett_mu(Q, W);

  localparam int S1W = TAG_W + XW;
  localparam int S2W = TAG_W + DW + TW;
  localparam int S3W = TAG_W + 2 * DW;
  localparam int S4W = TAG_W + W;

  logic en;
  assign en      = ~valid_o | ready_i;
  assign ready_o = en;

  // Stage 1: register the raw product
  logic             s1_vld;
  logic [S1W-1:0]   s1_dat;
  logic [TAG_W-1:0] s1_tag;
  logic [XW-1:0]    s1_x;

  mod_pipe_stage #(.DW(S1W)) u_s1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .valid_d(valid_i), .data_d({tag_i, x_i}),
    .valid_q(s1_vld), .data_q(s1_dat)
  );
  assign {s1_tag, s1_x} = s1_dat;

  // Stage 2: quotient-estimate numerator t
  logic [TW-1:0]    s2_t_d;
  logic             s2_vld;
  logic [S2W-1:0]   s2_dat;
  logic [TAG_W-1:0] s2_tag;
  logic [DW-1:0]    s2_x;
  logic [TW-1:0]    s2_t;

  assign s2_t_d = TW'(s1_x >> (W - 1)) * TW'(BMU);

  mod_pipe_stage #(.DW(S2W)) u_s2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .valid_d(s1_vld), .data_d({s1_tag, s1_x[DW-1:0], s2_t_d}),
    .valid_q(s2_vld), .data_q(s2_dat)
  );
  assign {s2_tag, s2_x, s2_t} = s2_dat;

  // Stage 3: quotient estimate qh and its multiple p = qh*Q (low DW bits)
  logic [QHW-1:0]   s3_qh;
  logic [DW-1:0]    s3_p_d;
  logic             s3_vld;
  logic [S3W-1:0]   s3_dat;
  logic [TAG_W-1:0] s3_tag;
  logic [DW-1:0]    s3_x;
  logic [DW-1:0]    s3_p;

  assign s3_qh  = QHW'(s2_t >> (W + 1));
  assign s3_p_d = DW'(PW'(s3_qh) * PW'(Q));

  mod_pipe_stage #(.DW(S3W)) u_s3 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .valid_d(s2_vld), .data_d({s2_tag, s2_x, s3_p_d}),
    .valid_q(s3_vld), .data_q(s3_dat)
  );
  assign {s3_tag, s3_x, s3_p} = s3_dat;

  // Stage 4: remainder estimate d < 3Q, corrected by at most two subtractions of Q
  logic [DW-1:0] d;
  logic [W-1:0]  r_d;

  // Final correction: d in [0,3Q) folded into [0,Q)
  always_comb begin
    d   = s3_x - s3_p;
    r_d = W'(d);
    if (d >= DW'(2 * Q)) begin
      r_d = W'(d - DW'(2 * Q));
    end else if (d >= DW'(Q)) begin
      r_d = W'(d - DW'(Q));
    end
  end

  mod_pipe_stage #(.DW(S4W)) u_s4 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .valid_d(s3_vld), .data_d({s3_tag, r_d}),
    .valid_q(valid_o), .data_q({tag_o, r_o})
  );

`ifdef MOD_BARRETT_RANGE_CHECK_EN
  localparam logic [XW-1:0] X_MAX = XW'((Q - 1) * (Q - 1));

  // Sticky flag: any accepted product outside the legal (Q-1)**2 range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_o <= 1'b0;
    end else if (valid_i && en && (x_i > X_MAX)) begin
      range_err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_barrett_reduce.sv
// Randomised scoreboard bench for mod_barrett_reduce: reference model is plain x % Q.
// Accepted inputs are queued at the negedge before the accepting edge; outputs popped on valid_o & ready_i.
// Also covers latency, stall hold, mid-stream reset and the optional range flag.
module tb_mod_barrett_reduce;
  import ntt_pkg::*;

  localparam int Q     = NTT_Q;
  localparam int W     = NTT_W;
  localparam int TAG_W = 8;

  logic             clk;
  logic             rst_n;
  logic             valid_i;
  logic             ready_o;
  prod_t            x_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [W-1:0]     r_o;
  logic [TAG_W-1:0] tag_o;
`ifdef MOD_BARRETT_RANGE_CHECK_EN
  logic             range_err_o;
`endif

  mod_barrett_reduce #(.W(W), .Q(Q), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .ready_o(ready_o), .x_i(x_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .r_o(r_o), .tag_o(tag_o)
`ifdef MOD_BARRETT_RANGE_CHECK_EN
    , .range_err_o(range_err_o)
`endif
  );

  typedef struct {
    prod_t            x;
    logic [TAG_W-1:0] tag;
    bit               chk_r;
    bit               chk_lat;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rnd_ready = 0;
  bit   lat_flag = 0;
  bit   rchk_flag = 1;
  bit   prev_stall = 0;
  logic [W-1:0]     prev_r;
  logic [TAG_W-1:0] prev_tag;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Record every transfer into the pipe
  always @(negedge clk) begin : push_proc
    exp_t e;
    if (rst_n && valid_i && ready_o) begin
      e.x = x_i; e.tag = tag_i; e.chk_r = rchk_flag; e.chk_lat = lat_flag; e.cyc = cyc;
      sb.push_back(e);
    end
  end

  // Check every transfer out of the pipe, plus stall stability
  always @(negedge clk) begin : mon_proc
    exp_t e;
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid_held", valid_o, 1);
        chk("stall_r_held", r_o, prev_r);
        chk("stall_tag_held", tag_o, prev_tag);
      end
      if (valid_o && !ready_i) chk("stall_ready_low", ready_o, 0);
      if (valid_o && ready_i) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: r=%0d tag=%0h with empty scoreboard", r_o, tag_o);
        end else begin
          e = sb.pop_front();
          if (e.chk_r) chk("r_value", r_o, longint'(e.x % Q));
          chk("tag_value", tag_o, e.tag);
          if (e.chk_lat) chk("latency", cyc - e.cyc, 4);
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_r     = r_o;
      prev_tag   = tag_o;
    end else begin
      prev_stall = 0;
    end
  end

  // Random downstream backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input prod_t x, input logic [TAG_W-1:0] tag);
    int k;
    valid_i = 1'b1; x_i = x; tag_i = tag;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (ready_o) break;
    end
    if (k == 1000) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: ready_o stayed %0d, expected 1", ready_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && sb.size() != 0; k++) @(negedge clk);
    @(posedge clk); #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int vcnt;
    rst_n = 1'b0; valid_i = 1'b0; x_i = '0; tag_i = '0; ready_i = 1'b0;
    #12;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_r_o", r_o, 0);
    chk("rst_tag_o", tag_o, 0);
    chk("rst_ready_o", ready_o, 1);
`ifdef MOD_BARRETT_RANGE_CHECK_EN
    chk("rst_range_err", range_err_o, 0);
`endif
    ready_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Single zero product, latency measured
    lat_flag = 1;
    send('0, 8'h11);
    drain();

    // Back-to-back directed stream; equal latency implies consecutive outputs
    send(prod_t'(150994944), 8'h21);
    send(prod_t'(12289), 8'h22);
    send(prod_t'(12290), 8'h23);
    send(prod_t'(30000000), 8'h24);
    lat_flag = 0;
    drain();

    // Eight values with a 3-cycle downstream stall while valid_o is up
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(prod_t'($urandom_range(0, (Q - 1) * (Q - 1))), 8'(8'h40 + i));
      end
      begin
        for (int k = 0; k < 50 && !valid_o; k++) @(negedge clk);
        @(posedge clk); #1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();

    // Randomised products with random bubbles and backpressure
    rnd_ready = 1;
    for (int i = 0; i < 10000; i++) begin
      int a, b;
      a = int'($urandom_range(0, Q - 1));
      b = int'($urandom_range(0, Q - 1));
      if ($urandom_range(0, 3) == 0) idle(1);
      send(prod_t'(a * b), 8'(i));
    end
    rnd_ready = 0;
    ready_i = 1'b1;
    drain();

    // Reset with data in flight and the output stalled
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(prod_t'(1000 + i), 8'(8'h80 + i));
    chk("pre_reset_valid_o", valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_valid_o_async", valid_o, 0);
    chk("reset_r_o_async", r_o, 0);
    chk("reset_tag_o_async", tag_o, 0);
    sb.delete();
    ready_i = 1'b1;
    idle(2);
    rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid_o) vcnt++;
    end
    chk("post_reset_no_stale", vcnt, 0);
    @(posedge clk); #1;

`ifdef MOD_BARRETT_RANGE_CHECK_EN
    // Out-of-range product sets the sticky flag until reset
    chk("range_err_before", range_err_o, 0);
    rchk_flag = 0;
    send(prod_t'(Q * Q), 8'hA5);
    rchk_flag = 1;
    chk("range_err_set", range_err_o, 1);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk("range_err_sticky", range_err_o, 1);
    end
    drain();
    chk("range_err_after_drain", range_err_o, 1);
    rst_n = 1'b0;
    #1;
    chk("range_err_reset", range_err_o, 0);
    idle(1);
    rst_n = 1'b1;
    idle(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
